sel_mux_skid: RTL

//  Parametrised N:1 datapath select with a registered output and a valid/ready handshake.
//  A 2-entry skid buffer decouples the producer from the consumer.

---
 rtl/sel_mux_skid.sv | 115 +++++++++++
 1 files changed

// File: rtl/sel_mux_skid.sv
// N:1 registered select feeding a 2-entry skid FIFO with a valid/ready handshake.
// Out-of-range selects emit DEF_VAL with an error flag; also keeps a sticky error and a beat counter.
module sel_mux_skid #(
  parameter int              WIDTH   = 32,
  parameter int              N_IN    = 4,
  parameter int              SEL_W   = $clog2(N_IN),
  parameter logic [WIDTH-1:0] DEF_VAL = '0,
  parameter int              CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_sticky,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      beat_cnt
);

  // state | meaning
  // EMPTY | no beat held; out_data/out_err keep their last value
  // ONE   | head register holds the oldest beat
  // FULL  | head plus skid both hold beats; producer stalled
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic [WIDTH-1:0] beat_data;
  logic             beat_err;
  logic             push;
  logic             pop;

  // Match against each legal channel; anything unmatched falls through to DEF_VAL.
  always_comb begin
    beat_data = DEF_VAL;
    beat_err  = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == i[SEL_W-1:0]) begin
        beat_data = in_data[i*WIDTH +: WIDTH];
        beat_err  = 1'b0;
      end
    end
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            out_data <= beat_data;
            out_err  <= beat_err;
            state    <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_data <= beat_data;
            out_err  <= beat_err;
          end else if (push) begin
            skid_data <= beat_data;
            skid_err  <= beat_err;
            state     <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            out_data <= skid_data;
            out_err  <= skid_err;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // A new error on the same cycle as err_clr takes priority over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else if (push && beat_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule
